// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv
// Purpose  : HI/LO register file with a multi-cycle multiply/divide engine
//            for the MIPS execute stage. Performs signed/unsigned MULT, DIV,
//            MADD and MSUB into HI/LO and accepts direct MTHI/MTLO writes.
// Ports    : clk      - clock, all state updates on the rising edge
//            rst      - asynchronous reset, active low
//            start    - launch operation selected by op (sampled in IDLE)
//            op       - 000 MULT 001 MULTU 010 DIV 011 DIVU
//                       100 MADD 101 MADDU 110 MSUB 111 MSUBU
//            a, b     - operands (dividend / divisor for DIV/DIVU)
//            hi_we/lo_we, hi_i/lo_i - direct HI/LO writes (IDLE only)
//            flush    - synchronous abort of the in-flight operation
//            busy     - operation in flight (registered)
//            done     - one-cycle completion pulse (registered)
//            div_zero - one-cycle pulse on DIV/DIVU completion with b == 0
//            hi_o/lo_o - HI and LO registers
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    // Counter must reach WIDTH (divide sign-fix step) and MUL_LAT-1.
    localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] C_MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] C_DIV_FIX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t             r_state;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;       // raw rt for multiply, |divisor| for divide
    logic [2*WIDTH-1:0] r_acc;     // {HI,LO} captured at the start edge
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;     // dividend shifts out as quotient shifts in
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;

    // ------------------------------------------------------------------
    // Operation decode and divide operand magnitudes (from live inputs)
    // ------------------------------------------------------------------
    logic             w_is_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_is_div = (op[2:1] == 2'b01);
    assign w_a_neg  = ~op[0] & a[WIDTH-1];
    assign w_b_neg  = ~op[0] & b[WIDTH-1];
    // Most-negative value negates to itself, which is its correct unsigned magnitude.
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    // ------------------------------------------------------------------
    // Multiplier: operands extended to 2*WIDTH so a single modular product
    // serves both signed and unsigned forms.
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_ma;
    logic [2*WIDTH-1:0] w_mb;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_mul_res;

    assign w_ma   = r_op[0] ? {{WIDTH{1'b0}}, r_a} : {{WIDTH{r_a[WIDTH-1]}}, r_a};
    assign w_mb   = r_op[0] ? {{WIDTH{1'b0}}, r_b} : {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_prod = w_ma * w_mb;

    always_comb begin
        w_mul_res = w_prod;
        if (r_op[2]) begin
            w_mul_res = r_op[1] ? (r_acc - w_prod) : (r_acc + w_prod);
        end
    end

    // ------------------------------------------------------------------
    // Restoring divide step. The remainder after subtraction is below the
    // divisor, so a WIDTH-bit modular subtraction yields it exactly.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_shift;
    logic             w_fits;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_fits  = (w_shift >= {1'b0, r_b});
    assign w_sub   = w_shift[WIDTH-1:0] - r_b;
    assign w_q_fix = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix = r_neg_r ? -r_rem : r_rem;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_o     <= '0;
            lo_o     <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;

            // Direct writes only while idle and not launching; still honoured
            // alongside a flush because flush does not gate them.
            if (r_state == S_IDLE && !start) begin
                if (hi_we) hi_o <= hi_i;
                if (lo_we) lo_o <= lo_i;
            end

            if (flush) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_op  <= op;
                            r_a   <= a;
                            r_b   <= b;
                            r_acc <= {hi_o, lo_o};
                            r_cnt <= '0;
                            busy  <= 1'b1;
                            if (w_is_div) begin
                                r_state <= S_DIV;
                                r_b     <= w_b_mag;
                                r_quo   <= w_a_mag;
                                r_rem   <= '0;
                                r_neg_q <= w_a_neg ^ w_b_neg;
                                r_neg_r <= w_a_neg;
                                r_dz    <= (b == '0);
                            end else begin
                                r_state <= S_MUL;
                            end
                        end
                    end

                    S_MUL: begin
                        if (r_cnt == C_MUL_LAST) begin
                            {hi_o, lo_o} <= w_mul_res;
                            r_state      <= S_IDLE;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + C_CNT_ONE;
                        end
                    end

                    S_DIV: begin
                        if (r_dz) begin
                            // Divide by zero: finish immediately, HI/LO untouched.
                            r_state  <= S_IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else if (r_cnt == C_DIV_FIX) begin
                            hi_o    <= w_r_fix;
                            lo_o    <= w_q_fix;
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_rem <= w_fits ? w_sub : w_shift[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], w_fits};
                            r_cnt <= r_cnt + C_CNT_ONE;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
